// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: state codes, opcodes,
// and the ALU/PC select values that the datapath decodes.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH0 = 4'd0,
      S_FETCH1 = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_ADDIEX = 4'd11,
      S_ADDIWB = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [2:0] SRCB_REG   = 3'b000;
   localparam logic [2:0] SRCB_FOUR  = 3'b001;
   localparam logic [2:0] SRCB_IMM   = 3'b010;
   localparam logic [2:0] SRCB_SHIMM = 3'b011;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write_cond;
      logic       pc_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       alu_src_a;
      logic       reg_write;
      logic       reg_dst;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
      logic [2:0] alu_src_b;
   } ctrl_t;

   function automatic logic is_supported(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Moore output decoder: maps the current control state to datapath control lines.
module ctrl_output_decode
   import mips_ctrl_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   always_comb begin
      // NOTE: everything defaults to 0 before the case so no path leaves a signal
      // unassigned; that is what keeps this purely combinational (no latches).
      ctrl = '0;
      unique case (state)
         S_FETCH0: ctrl.mem_read = 1'b1;
         S_FETCH1: begin
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_source = PC_ALU;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_SHIMM;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.mem_read  = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALU_FUNCT;
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_REG;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PC_BRANCH;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PC_JUMP;
         end
         S_ADDIWB: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.reg_write = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register and next-state logic; outputs come
// from ctrl_output_decode so they depend on the state register alone.
module multicycle_control
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opCode,
   output logic       PCWriteCond,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic [1:0] PCSource,
   output logic [1:0] ALUOp,
   output logic [2:0] ALUSrcB,
   output logic [3:0] state_o,
   output logic       illegal_op
);

   state_t state_q, state_d;
   logic   illegal_q, illegal_d;
   ctrl_t  ctrl;

   // NOTE: reset is asynchronous so an in-flight write enable drops the moment
   // reset falls, not at the next edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH0;
         illegal_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = S_FETCH0;
      illegal_d = 1'b0;
      case (state_q)
         S_FETCH0: state_d = S_FETCH1;
         S_FETCH1: state_d = S_DECODE;
         S_DECODE: begin
            illegal_d = !is_supported(opCode);
            case (opCode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
               default:      state_d = S_FETCH0;
            endcase
         end
         S_MEMADR: state_d = (opCode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         default:  state_d = S_FETCH0;   // terminal states and unused codes 13-15
      endcase
   end

   ctrl_output_decode u_decode (
      .state (state_q),
      .ctrl  (ctrl)
   );

   assign PCWriteCond = ctrl.pc_write_cond;
   assign PCWrite     = ctrl.pc_write;
   assign IorD        = ctrl.i_or_d;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign IRWrite     = ctrl.ir_write;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign RegWrite    = ctrl.reg_write;
   assign RegDst      = ctrl.reg_dst;
   assign PCSource    = ctrl.pc_source;
   assign ALUOp       = ctrl.alu_op;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign state_o     = state_q;
   assign illegal_op  = illegal_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state changes occur on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: opCode  input  6  instruction opcode from the instruction register.
REQ-004 SHALL have 1-bit outputs PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, each with the datapath meaning of the same name.
REQ-005 SHALL have port: PCSource  output  2  PC source select: 00 ALU result, 01 ALU result (branch), 10 jump target.
REQ-006 SHALL have port: ALUOp  output  2  ALU operation: 00 add, 01 subtract, 10 use funct field.
REQ-007 SHALL have port: ALUSrcB  output  3  ALU B select: 000 B, 001 constant 4, 010 sign-extended immediate, 011 shifted immediate; bit 2 is always 0.
REQ-008 SHALL have port: state_o  output  4  current state code, for debug.
REQ-009 SHALL have port: illegal_op  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-010 SHALL be a Moore FSM: all outputs decode from the state register only; unlisted outputs are 0 in every state.
REQ-011 SHALL use state codes FETCH0=0, FETCH1=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12; codes 13-15 go to FETCH0 on the next edge.
REQ-012 SHALL drive in FETCH0: MemRead=1, IorD=0; next state FETCH1. This covers the one-cycle read latency of the synchronous RAM.
REQ-013 SHALL drive in FETCH1: MemRead=1, IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=001, ALUOp=00, PCSource=00; next state DECODE.
REQ-014 SHALL drive in DECODE: ALUSrcA=0, ALUSrcB=011, ALUOp=00.
REQ-015 SHALL branch from DECODE on opCode: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 -> EXEC; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP; 001000 (addi) -> ADDIEX; any other -> FETCH0.
REQ-016 SHALL assert illegal_op for exactly the one cycle following the DECODE cycle that saw an unsupported opcode.
REQ-017 SHALL drive in MEMADR: ALUSrcA=1, ALUSrcB=010, ALUOp=00; next MEMRD if opCode=100011, else MEMWR.
REQ-018 SHALL drive in MEMRD: MemRead=1, IorD=1, with ALU controls held as in MEMADR; next MEMWB.
REQ-019 SHALL drive in MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next FETCH0.
REQ-020 SHALL drive in MEMWR: MemWrite=1, IorD=1, with ALU controls as in MEMADR; next FETCH0.
REQ-021 SHALL drive in EXEC: ALUSrcA=1, ALUSrcB=000, ALUOp=10; next ALUWB.
REQ-022 SHALL drive in ALUWB: the EXEC ALU controls plus RegWrite=1, RegDst=1, MemtoReg=0; next FETCH0.
REQ-023 SHALL drive in BRANCH: ALUSrcA=1, ALUSrcB=000, ALUOp=01, PCWriteCond=1, PCSource=01; next FETCH0.
REQ-024 SHALL drive in JUMP: PCWrite=1, PCSource=10; next FETCH0.
REQ-025 SHALL drive in ADDIEX: ALUSrcA=1, ALUSrcB=010, ALUOp=00; next ADDIWB.
REQ-026 SHALL drive in ADDIWB: the ADDIEX ALU controls plus RegWrite=1, RegDst=0, MemtoReg=0; next FETCH0.
REQ-027 SHALL read opCode only in DECODE and MEMADR; changes to opCode in other states SHALL have no effect.
REQ-028 SHALL keep every write enable (PCWrite, PCWriteCond, MemWrite, RegWrite, IRWrite) glitch-free, never asserting one outside its listed states.

Reset
REQ-029 SHALL force the state to FETCH0 immediately when reset=0, independent of clk, and hold it there while reset=0.
REQ-030 SHALL present outputs during and after reset: MemRead=1, state_o=0, illegal_op=0, all other outputs 0.
REQ-031 SHALL abandon any in-flight instruction on reset assertion, including in MEMWR or ALUWB; the write enable drops within the same cycle.

Structure
REQ-032 SHALL define the state codes, opcode constants, and ALUOp/ALUSrcB/PCSource encodings in a shared package, mips_ctrl_pkg, that the datapath also uses.
REQ-033 SHALL use one sub-module, ctrl_output_decode, as the combinational decoder from state to outputs; the next-state logic and state register SHALL stay in multicycle_control.

Verification
REQ-034 SHALL include reset: release reset, opCode=000000 -> states 0,1,2,7,8,0; RegWrite=1 and RegDst=1 only in state 8.
REQ-035 SHALL include lw: opCode=100011 -> states 0,1,2,3,4,5,0; IorD=1 in state 4; MemtoReg=1 and RegWrite=1 in state 5.
REQ-036 SHALL include sw and beq: opCode=101011 -> MemWrite=1 only in state 6; opCode=000100 -> PCWriteCond=1 and ALUOp=01 only in state 9.
REQ-037 SHALL include an illegal opcode: opCode=111111 -> DECODE then FETCH0, illegal_op=1 for one cycle, no write enable asserted.
REQ-038 SHALL include reset mid-operation: pull reset=0 mid-cycle in state 6 -> MemWrite falls asynchronously, state_o=0 before the next edge.
